// File: rtl/vga_sync_if.sv
// Raster timing bundle from vga_sync: pixel/line position, syncs and frame markers.
interface vga_sync_if;
   logic [10:0] Columna;
   logic [9:0]  Fila;
   logic        HSYNC;
   logic        VSYNC;
   logic        Visible;
   logic        FrameStart;
   logic [5:0]  Frame;

   modport master (output Columna, Fila, HSYNC, VSYNC, Visible, FrameStart, Frame);
   modport slave  (input  Columna, Fila, HSYNC, VSYNC, Visible, FrameStart, Frame);
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel/line counters, registered syncs, frame pulse and counter.
// Define VGA_SYNC_DELAY_EN to delay HSYNC/VSYNC/Visible by two extra cycles for the renderer ROM.
module vga_sync #(
   parameter int H_VIS    = 800,
   parameter int H_FP     = 56,
   parameter int H_SW     = 120,
   parameter int H_BP     = 64,
   parameter int V_VIS    = 600,
   parameter int V_FP     = 37,
   parameter int V_SW     = 6,
   parameter int V_BP     = 23,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic       NCLK,
   input  logic       NRST,
   vga_sync_if.master o_vga
);

   localparam int          H_TOT   = H_VIS + H_FP + H_SW + H_BP;
   localparam int          V_TOT   = V_VIS + V_FP + V_SW + V_BP;
   localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
   localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SW - 1);
   localparam logic [10:0] H_VIS_W = 11'(H_VIS);
   localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SW - 1);
   localparam logic [9:0]  V_VIS_W = 10'(V_VIS);

   logic [10:0] r_col;
   logic [9:0]  r_row;
   logic        r_hs;
   logic        r_vs;
   logic        r_vis;
   logic        r_fs;
   logic [5:0]  r_frame;

   logic        w_col_wrap;
   logic [10:0] w_col_nxt;
   logic [9:0]  w_row_nxt;
   logic        w_origin;

   assign w_col_wrap = (r_col == H_LAST);
   assign w_col_nxt  = w_col_wrap ? 11'd0 : r_col + 11'd1;
   assign w_row_nxt  = !w_col_wrap      ? r_row :
                       (r_row == V_LAST) ? 10'd0 : r_row + 10'd1;
   assign w_origin   = (w_col_nxt == 11'd0) && (w_row_nxt == 10'd0);

   // Flags decode the next-count values so they land in the same cycle as the counters.
   // NOTE: sequential state uses nonblocking assignments so every register sees pre-edge values.
   always_ff @(posedge NCLK) begin
      if (!NRST) begin
         r_col   <= '0;
         r_row   <= '0;
         r_hs    <= ~SYNC_POL;
         r_vs    <= ~SYNC_POL;
         r_vis   <= 1'b0;
         r_fs    <= 1'b0;
         r_frame <= '0;
      end else begin
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         r_hs    <= (w_col_nxt >= HS_BEG && w_col_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
         r_vs    <= (w_row_nxt >= VS_BEG && w_row_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
         r_vis   <= (w_col_nxt < H_VIS_W) && (w_row_nxt < V_VIS_W);
         r_fs    <= w_origin;
         if (w_origin) begin
            r_frame <= r_frame + 6'd1;
         end
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   logic [1:0] r_hs_dly;
   logic [1:0] r_vs_dly;
   logic [1:0] r_vis_dly;

   always_ff @(posedge NCLK) begin
      if (!NRST) begin
         r_hs_dly  <= {2{~SYNC_POL}};
         r_vs_dly  <= {2{~SYNC_POL}};
         r_vis_dly <= 2'b00;
      end else begin
         r_hs_dly  <= {r_hs_dly[0], r_hs};
         r_vs_dly  <= {r_vs_dly[0], r_vs};
         r_vis_dly <= {r_vis_dly[0], r_vis};
      end
   end

   assign o_vga.HSYNC   = r_hs_dly[1];
   assign o_vga.VSYNC   = r_vs_dly[1];
   assign o_vga.Visible = r_vis_dly[1];
`else
   assign o_vga.HSYNC   = r_hs;
   assign o_vga.VSYNC   = r_vs;
   assign o_vga.Visible = r_vis;
`endif

   assign o_vga.Columna    = r_col;
   assign o_vga.Fila       = r_row;
   assign o_vga.FrameStart = r_fs;
   assign o_vga.Frame      = r_frame;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-geometry instance for line timing and a shrunken one for frame-level behaviour.
module tb_vga_sync;

   typedef struct packed {
      int hv; int hfp; int hsw; int hbp;
      int vv; int vfp; int vsw; int vbp;
   } geo_t;

   typedef struct packed {
      logic [10:0] col;
      logic [9:0]  row;
      logic        hs;
      logic        vs;
      logic        vis;
      logic        fs;
      logic [5:0]  frame;
   } obs_t;

   localparam geo_t G_FULL  = '{800, 56, 120, 64, 600, 37, 6, 23};
   localparam geo_t G_SMALL = '{16, 4, 6, 6, 12, 3, 2, 3};
   localparam int   S_HT    = 32;
   localparam int   S_FT    = 640;
`ifdef VGA_SYNC_DELAY_EN
   localparam int   DLY     = 2;
`else
   localparam int   DLY     = 0;
`endif

   logic NCLK = 1'b0;
   logic rst_n_full;
   logic rst_n_small;
   int   t_full;
   int   t_small;
   int   n_checks;
   int   n_fail;

   vga_sync_if u_if_full ();
   vga_sync_if u_if_small ();

   vga_sync u_dut_full (
      .NCLK  (NCLK),
      .NRST  (rst_n_full),
      .o_vga (u_if_full)
   );

   vga_sync #(
      .H_VIS (16), .H_FP (4), .H_SW (6), .H_BP (6),
      .V_VIS (12), .V_FP (3), .V_SW (2), .V_BP (3),
      .SYNC_POL (1'b1)
   ) u_dut_small (
      .NCLK  (NCLK),
      .NRST  (rst_n_small),
      .o_vga (u_if_small)
   );

   always #5 NCLK = ~NCLK;

   // Expected outputs t cycles after reset release (t=0: still in reset), straight from the raster arithmetic.
   function automatic obs_t model(geo_t g, int t);
      obs_t e;
      int ht, vt, ft, p, pc, pr;
      ht = g.hv + g.hfp + g.hsw + g.hbp;
      vt = g.vv + g.vfp + g.vsw + g.vbp;
      ft = ht * vt;
      e.col   = 11'(t % ht);
      e.row   = 10'((t / ht) % vt);
      e.fs    = (t > 0) && (t % ft == 0);
      e.frame = 6'((t / ft) % 64);
      e.hs    = 1'b0;
      e.vs    = 1'b0;
      e.vis   = 1'b0;
      p = t - DLY;
      if (p >= 1) begin
         pc    = p % ht;
         pr    = (p / ht) % vt;
         e.hs  = (pc >= g.hv + g.hfp) && (pc <= g.hv + g.hfp + g.hsw - 1);
         e.vs  = (pr >= g.vv + g.vfp) && (pr <= g.vv + g.vfp + g.vsw - 1);
         e.vis = (pc < g.hv) && (pr < g.vv);
      end
      return e;
   endfunction

   function automatic obs_t sample_full();
      return {u_if_full.Columna, u_if_full.Fila, u_if_full.HSYNC, u_if_full.VSYNC,
              u_if_full.Visible, u_if_full.FrameStart, u_if_full.Frame};
   endfunction

   function automatic obs_t sample_small();
      return {u_if_small.Columna, u_if_small.Fila, u_if_small.HSYNC, u_if_small.VSYNC,
              u_if_small.Visible, u_if_small.FrameStart, u_if_small.Frame};
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("col=%0d row=%0d hs=%b vs=%b vis=%b fs=%b frame=%0d",
                       o.col, o.row, o.hs, o.vs, o.vis, o.fs, o.frame);
   endfunction

   // One rising edge, then park on the falling edge where outputs are sampled and inputs driven.
   task automatic step();
      @(posedge NCLK);
      t_full  = rst_n_full  ? t_full + 1  : 0;
      t_small = rst_n_small ? t_small + 1 : 0;
      @(negedge NCLK);
   endtask

   task automatic test_reset();
      obs_t o, e;
      rst_n_full  = 1'b0;
      rst_n_small = 1'b0;
      repeat ($urandom_range(2, 5)) begin
         step();
         o = sample_full();
         e = model(G_FULL, 0);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_full got %s want %s", fmt(o), fmt(e));
         end
         o = sample_small();
         e = model(G_SMALL, 0);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_small got %s want %s", fmt(o), fmt(e));
         end
      end
      rst_n_full  = 1'b1;
      rst_n_small = 1'b1;
   endtask

   task automatic test_line();
      obs_t o, e;
      logic hs_by_col  [1040];
      logic vis_by_col [1040];
      int   hs_cnt;
      int   prev_col;
      hs_cnt   = 0;
      prev_col = 0;
      for (int i = 1; i <= 1040; i++) begin
         step();
         o = sample_full();
         e = model(G_FULL, t_full);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL line t=%0d got %s want %s", t_full, fmt(o), fmt(e));
         end
         hs_by_col[o.col]  = o.hs;
         vis_by_col[o.col] = o.vis;
         if (o.hs === 1'b1) hs_cnt++;
         if (o.col == 11'd0) begin
            n_checks++;
            if (o.row !== 10'd1 || prev_col != 1039) begin
               n_fail++;
               $display("FAIL line_wrap got row=%0d prev_col=%0d want row=1 prev_col=1039", o.row, prev_col);
            end
         end
         prev_col = int'(o.col);
      end
      n_checks++;
      if (hs_cnt != 120) begin
         n_fail++;
         $display("FAIL hsync_width got %0d want 120", hs_cnt);
      end
`ifdef VGA_SYNC_DELAY_EN
      n_checks++;
      if (hs_by_col[857] !== 1'b0 || hs_by_col[858] !== 1'b1) begin
         n_fail++;
         $display("FAIL hsync_delay got hs@857=%b hs@858=%b want 0 1", hs_by_col[857], hs_by_col[858]);
      end
      n_checks++;
      if (vis_by_col[801] !== 1'b1 || vis_by_col[802] !== 1'b0) begin
         n_fail++;
         $display("FAIL visible_delay got vis@801=%b vis@802=%b want 1 0", vis_by_col[801], vis_by_col[802]);
      end
`else
      n_checks++;
      if (hs_by_col[855] !== 1'b0 || hs_by_col[856] !== 1'b1 ||
          hs_by_col[975] !== 1'b1 || hs_by_col[976] !== 1'b0) begin
         n_fail++;
         $display("FAIL hsync_edges got %b%b%b%b want 0110", hs_by_col[855], hs_by_col[856],
                  hs_by_col[975], hs_by_col[976]);
      end
      n_checks++;
      if (vis_by_col[799] !== 1'b1 || vis_by_col[800] !== 1'b0) begin
         n_fail++;
         $display("FAIL visible_edge got vis@799=%b vis@800=%b want 1 0", vis_by_col[799], vis_by_col[800]);
      end
`endif
   endtask

   task automatic test_frames();
      obs_t o, e;
      int   fs_cnt, last_fs, vs_cnt, edge_hits;
      rst_n_small = 1'b0;
      step();
      rst_n_small = 1'b1;
      fs_cnt    = 0;
      last_fs   = -1;
      vs_cnt    = 0;
      edge_hits = 0;
      for (int i = 1; i <= 2 * S_FT + 2; i++) begin
         step();
         o = sample_small();
         e = model(G_SMALL, t_small);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL frame t=%0d got %s want %s", t_small, fmt(o), fmt(e));
         end
         if (o.vs === 1'b1) vs_cnt++;
         if (o.fs === 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) begin
               n_checks++;
               if (t_small - last_fs != S_FT) begin
                  n_fail++;
                  $display("FAIL fs_period got %0d want %0d", t_small - last_fs, S_FT);
               end
            end
            last_fs = t_small;
         end
`ifndef VGA_SYNC_DELAY_EN
         if ((o.col == 11'd15 && o.row == 10'd11) || (o.col == 11'd16 && o.row == 10'd11) ||
             (o.col == 11'd0 && o.row == 10'd12)) begin
            edge_hits++;
            n_checks++;
            if (o.vis !== (o.col == 11'd15)) begin
               n_fail++;
               $display("FAIL visible_corner col=%0d row=%0d got %b want %b", o.col, o.row, o.vis, o.col == 11'd15);
            end
         end
`endif
      end
      n_checks++;
      if (fs_cnt != 2) begin
         n_fail++;
         $display("FAIL fs_count got %0d want 2", fs_cnt);
      end
      n_checks++;
      if (o.frame !== 6'd2) begin
         n_fail++;
         $display("FAIL frame_count got %0d want 2", o.frame);
      end
      n_checks++;
      if (vs_cnt != 2 * 2 * S_HT) begin
         n_fail++;
         $display("FAIL vsync_width got %0d want %0d", vs_cnt, 2 * 2 * S_HT);
      end
`ifndef VGA_SYNC_DELAY_EN
      n_checks++;
      if (edge_hits != 6) begin
         n_fail++;
         $display("FAIL visible_corner_hits got %0d want 6", edge_hits);
      end
`endif
   endtask

   task automatic test_mid_reset();
      obs_t o, e;
      bit   found;
      found = 1'b0;
      for (int i = 0; i < 2 * S_FT; i++) begin
         step();
         o = sample_small();
         e = model(G_SMALL, t_small);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL hunt t=%0d got %s want %s", t_small, fmt(o), fmt(e));
         end
         if (o.col == 11'd22 && o.row == 10'd15) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL hunt_timeout got no col=22 row=15 want found within %0d cycles", 2 * S_FT);
      end
      n_checks++;
      if (o.hs !== 1'b1 || o.vs !== 1'b1) begin
         n_fail++;
         $display("FAIL sync_active got hs=%b vs=%b want 1 1", o.hs, o.vs);
      end
      rst_n_small = 1'b0;
      repeat (1 + $urandom_range(0, 2)) begin
         step();
         o = sample_small();
         e = model(G_SMALL, 0);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mid_reset got %s want %s", fmt(o), fmt(e));
         end
      end
      rst_n_small = 1'b1;
      for (int i = 0; i < 2 * S_FT; i++) begin
         step();
         o = sample_small();
         e = model(G_SMALL, t_small);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL post_reset t=%0d got %s want %s", t_small, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_random_resets();
      obs_t o, e;
      bit   pick_full;
      for (int it = 0; it < 8; it++) begin
         repeat ($urandom_range(40, 1500)) begin
            step();
            o = sample_small();
            e = model(G_SMALL, t_small);
            n_checks++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL rand_small t=%0d got %s want %s", t_small, fmt(o), fmt(e));
            end
            o = sample_full();
            e = model(G_FULL, t_full);
            n_checks++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL rand_full t=%0d got %s want %s", t_full, fmt(o), fmt(e));
            end
         end
         pick_full = 1'($urandom_range(0, 1));
         if (pick_full) rst_n_full = 1'b0;
         else           rst_n_small = 1'b0;
         repeat ($urandom_range(1, 3)) begin
            step();
            o = pick_full ? sample_full() : sample_small();
            e = model(pick_full ? G_FULL : G_SMALL, 0);
            n_checks++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL rand_reset full=%0d got %s want %s", pick_full, fmt(o), fmt(e));
            end
         end
         rst_n_full  = 1'b1;
         rst_n_small = 1'b1;
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      t_full      = 0;
      t_small     = 0;
      rst_n_full  = 1'b0;
      rst_n_small = 1'b0;
      test_reset();
      test_line();
      test_frames();
      test_mid_reset();
      test_random_resets();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have parameter H_VIS, default 800, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 56, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SW, default 120, meaning HSYNC pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 64, meaning horizontal back porch in pixels (line total 1040).
REQ-005 The block SHALL have parameter V_VIS, default 600, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 37, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SW, default 6, meaning VSYNC pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 23, meaning vertical back porch in lines (frame total 666).
REQ-009 The block SHALL have parameter SYNC_POL, default 1, meaning active level of HSYNC and VSYNC.
REQ-010 The block SHALL have port NCLK, input, 1 bit: the pixel clock (50 MHz); all logic is on its rising edge.
REQ-011 The block SHALL have port NRST, input, 1 bit: synchronous, active-low reset.
REQ-012 The block SHALL have port Columna, output, 11 bits: current horizontal pixel count, feeding the character renderer.
REQ-013 The block SHALL have port Fila, output, 10 bits: current line count.
REQ-014 The block SHALL have port HSYNC, output, 1 bit: horizontal sync to the connector.
REQ-015 The block SHALL have port VSYNC, output, 1 bit: vertical sync to the connector.
REQ-016 The block SHALL have port Visible, output, 1 bit: high while the pixel is inside the active area.
REQ-017 The block SHALL have port FrameStart, output, 1 bit: one-cycle pulse at frame origin.
REQ-018 The block SHALL have port Frame, output, 6 bits: frame counter, free-running, used for blink effects.

Function
REQ-019 The Columna counter SHALL increment by 1 every NCLK cycle and wrap from H_VIS+H_FP+H_SW+H_BP-1 (1039) to 0.
REQ-020 The Fila counter SHALL increment by 1 only in the cycle Columna wraps, and SHALL wrap from V_VIS+V_FP+V_SW+V_BP-1 (665) to 0 in that same cycle.
REQ-021 HSYNC SHALL equal SYNC_POL while Columna is in [H_VIS+H_FP, H_VIS+H_FP+H_SW-1] (856..975), and SHALL equal the inverse of SYNC_POL otherwise.
REQ-022 VSYNC SHALL equal SYNC_POL while Fila is in [V_VIS+V_FP, V_VIS+V_FP+V_SW-1] (637..642), and SHALL equal the inverse of SYNC_POL otherwise.
REQ-023 Visible SHALL be 1 exactly when Columna<H_VIS and Fila<V_VIS.
REQ-024 HSYNC, VSYNC and Visible SHALL be registered, decoded from the next-count values, so that they are cycle-aligned with the Columna and Fila outputs (zero relative latency).
REQ-025 FrameStart SHALL be 1 in exactly the one cycle where Columna=0 and Fila=0.
REQ-026 Frame SHALL increment in the cycle FrameStart is asserted and SHALL wrap from 63 to 0.
REQ-027 Fila SHALL never change except in the Columna wrap cycle, and Columna and Fila SHALL never exceed their totals.

Reset
REQ-028 While NRST=0 at a rising NCLK edge, the block SHALL set Columna=0, Fila=0, Frame=0, Visible=0, FrameStart=0, and HSYNC=VSYNC=~SYNC_POL.
REQ-029 In the first cycle after NRST is released, the block SHALL set Columna=1, Fila=0, Visible=1; the frame-0 FrameStart pulse is not produced, and the first FrameStart occurs at the next wrap.
REQ-030 Reset asserted mid-frame SHALL take effect at the next edge regardless of counter state, without emitting a partial sync pulse afterwards.

Configuration
REQ-031 With macro VGA_SYNC_DELAY_EN defined, HSYNC, VSYNC and Visible SHALL each pass through an additional 2-stage register delay, reset to their inactive levels, to match the 2-cycle ROM latency of the downstream character renderer; Columna, Fila, FrameStart and Frame are undelayed.
REQ-032 Without VGA_SYNC_DELAY_EN, no extra delay stages SHALL exist and REQ-024 alignment SHALL hold.

Verification
REQ-033 Bench SHALL apply reset, then run one line -> Columna counts 1..1039, wraps to 0, and Fila goes 0->1 in that same cycle.
REQ-034 Bench SHALL sample HSYNC over one line -> high exactly for Columna 856..975 (120 cycles), low elsewhere.
REQ-035 Bench SHALL run two full frames (2*1040*666 cycles) -> VSYNC high for Fila 637..642 only, FrameStart pulses once per 692640 cycles, and Frame increments 0->1->2.
REQ-036 Bench SHALL check Visible at (799,599) -> 1; at (800,599) -> 0; at (0,600) -> 0.
REQ-037 Bench SHALL deassert NRST at Columna=900, Fila=640 with HSYNC/VSYNC active -> the next edge gives all outputs at reset values and syncs inactive.
REQ-038 With VGA_SYNC_DELAY_EN defined -> HSYNC rises exactly 2 cycles after Columna=856, and Visible falls 2 cycles after Columna=800.
